// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: major opcodes, ALU opcode encoding and
// the decoded-entry record that travels through the dispatch stage.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // bit3 selects the sub/arith variant, bits 2:0 are the funct3 class
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // opcode kept as a plain vector: illegal OP words may carry codes outside the enum
  typedef struct packed {
    logic [3:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } dec_entry_t;

  function automatic logic [31:0] sext_i_imm(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] u_imm(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/alu_dispatch_decode.sv
// Purely combinational RV32I ALU-class decoder: turns one instruction word
// plus its operands into a dispatch entry.
module alu_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output dec_entry_t  entry_o
);

  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [31:0] shamt_s;

  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];
  assign shamt_s  = {27'b0, instr_i[24:20]};

  // Decode major opcode into ALU opcode, operands and legality
  always_comb begin
    entry_o         = '0;
    entry_o.rd      = instr_i[11:7];
    entry_o.illegal = 1'b1;
    case (instr_i[6:0])
      OPC_OP: begin
        entry_o.opcode = {instr_i[30], funct3_s};
        entry_o.a      = rs1_i;
        entry_o.b      = rs2_i;
        if (funct7_s == F7_ZERO) begin
          entry_o.illegal = 1'b0;
        end else if ((funct7_s == F7_ALT) &&
                     ((funct3_s == 3'd0) || (funct3_s == 3'd5))) begin
          entry_o.illegal = 1'b0;
        end else begin
          entry_o.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // only the right-shift group uses instr[30] to pick its arith form
        entry_o.opcode = {((funct3_s == 3'd5) && instr_i[30]), funct3_s};
        entry_o.a      = rs1_i;
        case (funct3_s)
          3'd1: begin
            entry_o.b       = shamt_s;
            entry_o.illegal = (funct7_s != F7_ZERO);
          end
          3'd5: begin
            entry_o.b       = shamt_s;
            entry_o.illegal = !((funct7_s == F7_ZERO) || (funct7_s == F7_ALT));
          end
          default: begin
            entry_o.b       = sext_i_imm(instr_i);
            entry_o.illegal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        entry_o.opcode  = ALU_ADD;
        entry_o.a       = 32'd0;
        entry_o.b       = u_imm(instr_i);
        entry_o.illegal = 1'b0;
      end
      OPC_AUIPC: begin
        entry_o.opcode  = ALU_ADD;
        entry_o.a       = pc_i;
        entry_o.b       = u_imm(instr_i);
        entry_o.illegal = 1'b0;
      end
      default: begin
        entry_o.opcode  = ALU_ADD;
        entry_o.a       = 32'd0;
        entry_o.b       = 32'd0;
        entry_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_dispatch.sv
// ALU dispatch stage: decodes RV32I ALU instructions and holds them in a
// main output register backed by a one-entry skid register, so the upstream
// handshake never depends combinationally on out_ready.
module alu_dispatch
  import riscv_pkg::*;
#(
  parameter bit DROP_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_opcode,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  dec_entry_t dec_s;
  dec_entry_t main_q, main_d;
  dec_entry_t skid_q, skid_d;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       accept_s;
  logic       keep_s;

  alu_decode u_decode (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .rs1_i   (in_rs1_val),
    .rs2_i   (in_rs2_val),
    .entry_o (dec_s)
  );

  // the skid slot is the only thing that can refuse new work
  assign in_ready = !skid_valid_q;
  assign accept_s = in_valid && in_ready;
  // dropped illegal words still complete the handshake but are never stored
  assign keep_s   = accept_s && !(DROP_ILLEGAL && dec_s.illegal);

  // Next-state for main/skid entries: flush first, then drain skid, then accept
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // both slots full, no input can be accepted this cycle
      if (out_ready) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else if (main_valid_q && !out_ready) begin
      // output stalled: park the new entry so out_* stays stable
      if (keep_s) begin
        skid_d       = dec_s;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else begin
      // main empty or draining this cycle: new entry goes straight to main
      main_valid_d = keep_s;
      if (keep_s) begin
        main_d = dec_s;
      end else begin
        main_d = main_q;
      end
    end
  end

  // Entry registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_opcode  = main_q.opcode;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: a directed decode table, hand-built
// stall/flush/drop/reset sequences, and a randomized run scored against a
// queue-based reference model. dut[0] forwards illegal words, dut[1] drops them.
module tb_alu_dispatch;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
    logic        full;  // 0: only rd/illegal are defined for this word
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val;
  logic [1:0]  ir, ov, oi;
  logic [3:0]  oop [2];
  logic [31:0] oa [2];
  logic [31:0] ob [2];
  logic [4:0]  ord [2];

  int n_vec = 0;
  int n_err = 0;
  exp_t q [2][$];
  vec_t tbl [15];

  always #5 clk = ~clk;

  alu_dispatch #(.DROP_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_opcode(oop[0]), .out_a(oa[0]), .out_b(ob[0]), .out_rd(ord[0]), .out_illegal(oi[0])
  );

  alu_dispatch #(.DROP_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_opcode(oop[1]), .out_a(oa[1]), .out_b(ob[1]), .out_rd(ord[1]), .out_illegal(oi[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input int d, input exp_t e);
    chk({tag, " valid"}, 32'(ov[d]), 32'd1);
    if (e.full) begin
      chk({tag, " opcode"}, 32'(oop[d]), 32'(e.op));
      chk({tag, " a"}, oa[d], e.a);
      chk({tag, " b"}, ob[d], e.b);
    end
    chk({tag, " rd"}, 32'(ord[d]), 32'(e.rd));
    chk({tag, " illegal"}, 32'(oi[d]), 32'(e.ill));
  endtask

  function automatic exp_t mke(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic ill, input logic full);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.ill = ill; e.full = full;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.e = e;
    return v;
  endfunction

  // Reference decode, written straight from the RV32I field rules
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    int f3, f7, imm;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    imm = int'($signed(w[31:20]));
    e = mke(4'd0, 32'd0, 32'd0, w[11:7], 1'b1, 1'b1);
    if (w[6:0] == 7'h33) begin
      e.ill = !((f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)));
      e.full = !e.ill;
      e.op = 4'(f3 + (w[30] ? 8 : 0));
      e.a = rs1;
      e.b = rs2;
    end else if (w[6:0] == 7'h13) begin
      if (f3 == 1) e.ill = (f7 != 0);
      else if (f3 == 5) e.ill = !(f7 == 0 || f7 == 32);
      else e.ill = 1'b0;
      e.full = !e.ill;
      e.op = 4'(f3 + ((f3 == 5 && f7 == 32) ? 8 : 0));
      e.a = rs1;
      e.b = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : 32'(imm);
    end else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
      e.ill = 1'b0;
      e.a = (w[6:0] == 7'h17) ? pc : 32'd0;
      e.b = 32'(w[31:12]) * 32'd4096;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs1_val = rs1; in_rs2_val = rs2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7, major;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 7);
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    if (sel <= 2) major = 7'h33;
    else if (sel <= 5) major = 7'h13;
    else if (sel == 6) major = r[0] ? 7'h37 : 7'h17;
    else major = r[6:0];
    return {f7, r[24:7], major};
  endfunction

  initial begin
    exp_t e;
    logic acc, fire;

    tbl[0]  = mkv(32'h002081B3, 32'h0, 32'd5, 32'd7, mke(4'h0, 32'd5, 32'd7, 5'd3, 1'b0, 1'b1));
    tbl[1]  = mkv(32'h40435293, 32'h0, 32'h80000000, 32'h1234, mke(4'hD, 32'h80000000, 32'd4, 5'd5, 1'b0, 1'b1));
    tbl[2]  = mkv(32'h40031293, 32'h0, 32'd9, 32'd1, mke(4'h0, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0));
    tbl[3]  = mkv(32'h12345097, 32'h100, 32'hDEAD, 32'h0, mke(4'h0, 32'h100, 32'h12345000, 5'd1, 1'b0, 1'b1));
    tbl[4]  = mkv(32'hABCDE537, 32'h200, 32'h55, 32'h66, mke(4'h0, 32'h0, 32'hABCDE000, 5'd10, 1'b0, 1'b1));
    tbl[5]  = mkv(32'h40208233, 32'h0, 32'd10, 32'd3, mke(4'h8, 32'd10, 32'd3, 5'd4, 1'b0, 1'b1));
    tbl[6]  = mkv(32'hFFF08393, 32'h0, 32'h20, 32'h77, mke(4'h0, 32'h20, 32'hFFFFFFFF, 5'd7, 1'b0, 1'b1));
    tbl[7]  = mkv(32'h7FF13413, 32'h0, 32'h30, 32'h1, mke(4'h3, 32'h30, 32'h7FF, 5'd8, 1'b0, 1'b1));
    tbl[8]  = mkv(32'h4020E1B3, 32'h0, 32'h1, 32'h2, mke(4'h0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0));
    tbl[9]  = mkv(32'h0020D1B3, 32'h0, 32'hF0, 32'd2, mke(4'h5, 32'hF0, 32'd2, 5'd3, 1'b0, 1'b1));
    tbl[10] = mkv(32'h4020D1B3, 32'h0, 32'hF0, 32'd2, mke(4'hD, 32'hF0, 32'd2, 5'd3, 1'b0, 1'b1));
    tbl[11] = mkv(32'h00002083, 32'h300, 32'h44, 32'h55, mke(4'h0, 32'h0, 32'h0, 5'd1, 1'b1, 1'b1));
    tbl[12] = mkv(32'h01F35293, 32'h0, 32'h80000001, 32'h9, mke(4'h5, 32'h80000001, 32'h1F, 5'd5, 1'b0, 1'b1));
    tbl[13] = mkv(32'hFFF37293, 32'h0, 32'h1234, 32'h9, mke(4'h7, 32'h1234, 32'hFFFFFFFF, 5'd5, 1'b0, 1'b1));
    tbl[14] = mkv(32'h8000A493, 32'h0, 32'h7, 32'h9, mke(4'h2, 32'h7, 32'hFFFFF800, 5'd9, 1'b0, 1'b1));

    // reset state
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0; in_rs1_val = 32'h0; in_rs2_val = 32'h0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset valid", 32'(ov[d]), 32'd0);
      chk("reset in_ready", 32'(ir[d]), 32'd1);
      chk("reset fields", {oop[d], ord[d], oi[d]} | oa[d] | ob[d], 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();

    // decode table, one word per cycle with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2);
      chk($sformatf("tbl%0d in_ready", i), 32'(ir[0]), 32'd1);
      tick();
      chk_entry($sformatf("tbl%0d", i), 0, tbl[i].e);
    end
    in_valid = 1'b0;
    tick();
    chk("tbl drain", 32'(ov[0]), 32'd0);

    // stall: I0, I1 back to back, skid fills, then drain in order
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'h11, 32'h0);
    tick();
    chk("stall I0 a", oa[0], 32'h11);
    chk("stall in_ready after I0", 32'(ir[0]), 32'd1);
    drive(32'h002081B3, 32'h0, 32'h22, 32'h0);
    tick();
    chk("stall in_ready after I1", 32'(ir[0]), 32'd0);
    drive(32'h002081B3, 32'h0, 32'h33, 32'h0);
    tick();
    chk("stall hold a", oa[0], 32'h11);
    chk("stall hold in_ready", 32'(ir[0]), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain I1 valid", 32'(ov[0]), 32'd1);
    chk("drain I1 a", oa[0], 32'h22);
    chk("drain in_ready", 32'(ir[0]), 32'd1);
    tick();
    chk("drain empty", 32'(ov[0]), 32'd0);

    // flush with both entries full and a new input offered
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'h44, 32'h0); tick();
    drive(32'h002081B3, 32'h0, 32'h55, 32'h0); tick();
    chk("flush full in_ready", 32'(ir[0]), 32'd0);
    drive(32'h002081B3, 32'h0, 32'h66, 32'h0); flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush full valid", 32'(ov[0]), 32'd0);
    chk("flush full in_ready after", 32'(ir[0]), 32'd1);
    tick();
    chk("flush full no accept", 32'(ov[0]), 32'd0);
    // flush beats an input handshake when only main is full
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'h77, 32'h0); tick();
    drive(32'h002081B3, 32'h0, 32'h88, 32'h0); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush main valid", 32'(ov[0]), 32'd0);
    tick();
    chk("flush main no accept", 32'(ov[0]), 32'd0);

    // drop mode: add, illegal, xor
    out_ready = 1'b1;
    drive(32'h002081B3, 32'h0, 32'hA1, 32'h0); tick();
    chk("drop add valid", 32'(ov[1]), 32'd1);
    chk("drop add a", oa[1], 32'hA1);
    drive(32'hFFFFFFFF, 32'h0, 32'hA2, 32'h0);
    chk("drop illegal in_ready", 32'(ir[1]), 32'd1);
    tick();
    chk("drop illegal hidden", 32'(ov[1]), 32'd0);
    chk("fwd illegal flag", 32'(oi[0]), 32'd1);
    drive(32'h0020C1B3, 32'h0, 32'hA3, 32'h0); tick();
    chk("drop xor valid", 32'(ov[1]), 32'd1);
    chk("drop xor opcode", 32'(oop[1]), 32'h4);
    chk("drop xor a", oa[1], 32'hA3);
    in_valid = 1'b0; tick();
    chk("drop drain", 32'(ov[1]), 32'd0);

    // reset mid-stream with both entries held
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'hB1, 32'h0); tick();
    drive(32'h002081B3, 32'h0, 32'hB2, 32'h0); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid reset valid", 32'(ov[d]), 32'd0);
      chk("mid reset in_ready", 32'(ir[d]), 32'd1);
      chk("mid reset a", oa[d], 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post reset empty", 32'(ov[0]) | 32'(ov[1]), 32'd0);

    // randomized run against the queue model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rnd%0d c%0d valid", d, cyc), 32'(ov[d]), 32'(q[d].size() > 0));
        chk($sformatf("rnd%0d c%0d in_ready", d, cyc), 32'(ir[d]), 32'(q[d].size() < 2));
        if (q[d].size() > 0 && ov[d] === 1'b1) begin
          chk_entry($sformatf("rnd%0d c%0d", d, cyc), d, q[d][0]);
        end
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 63) == 0);
      in_instr  = rand_instr();
      in_pc = $urandom; in_rs1_val = $urandom; in_rs2_val = $urandom;
      e = ref_decode(in_instr, in_pc, in_rs1_val, in_rs2_val);
      for (int d = 0; d < 2; d++) begin
        if (flush) begin
          q[d].delete();
        end else begin
          fire = (q[d].size() > 0) && out_ready;
          acc  = in_valid && (q[d].size() < 2);
          if (fire) void'(q[d].pop_front());
          if (acc && !(d == 1 && e.ill)) q[d].push_back(e);
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
